// File: rtl/piso_tx_scheduler.sv
// Two-requester round-robin front end sharing one MSB-first serializer.
// Optional even-parity trailer bit per frame when PISO_PARITY_EN is defined.
module piso_tx_scheduler #(
   parameter int WIDTH = 4,
   parameter int GAP   = 0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_req0_valid,
   input  logic [WIDTH-1:0] i_req0_data,
   output logic             o_req0_ready,
   input  logic             i_req1_valid,
   input  logic [WIDTH-1:0] i_req1_data,
   output logic             o_req1_ready,
   output logic             o_so,
   output logic             o_so_valid,
   output logic             o_frame_start,
   output logic             o_grant_id,
   output logic             o_busy
);

   // state   | meaning
   // S_IDLE  | no frame in flight, accept window open
   // S_SHIFT | one frame bit on o_so per cycle
   // S_GAP   | forced idle cycles between frames

`ifdef PISO_PARITY_EN
   localparam int FLEN = WIDTH + 1;
`else
   localparam int FLEN = WIDTH;
`endif
   localparam int             CW     = $clog2(FLEN);
   localparam logic [CW-1:0]  LAST   = CW'(FLEN - 1);
   localparam logic [3:0]     GAP_LD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [FLEN-1:0] r_shreg;
   logic [CW-1:0]   r_cnt;
   logic [3:0]      r_gap;
   logic            r_grant;

   logic             w_last;
   logic             w_win;
   logic             w_rdy0;
   logic             w_rdy1;
   logic             w_acc;
   logic [WIDTH-1:0] w_word;
   logic [FLEN-1:0]  w_load;

   assign w_last = (r_state == S_SHIFT) && (r_cnt == LAST);
   assign w_win  = !i_rst && ((r_state == S_IDLE) || (w_last && (GAP == 0)));
   // On a tie the requester that did not win last time goes next.
   assign w_rdy0 = w_win && i_req0_valid && (!i_req1_valid || r_grant);
   assign w_rdy1 = w_win && i_req1_valid && (!i_req0_valid || !r_grant);
   assign w_acc  = w_rdy0 || w_rdy1;
   assign w_word = w_rdy1 ? i_req1_data : i_req0_data;

`ifdef PISO_PARITY_EN
   assign w_load = {w_word, ^w_word};
`else
   assign w_load = w_word;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_acc) w_next = S_SHIFT;
         S_SHIFT: begin
            if (w_last) begin
               if (w_acc)        w_next = S_SHIFT;
               else if (GAP > 0) w_next = S_GAP;
               else              w_next = S_IDLE;
            end
         end
         S_GAP:   if (r_gap == 4'd0) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_shreg <= '0;
         r_cnt   <= '0;
         r_gap   <= '0;
         r_grant <= 1'b1;
      end else begin
         if (w_acc) begin
            r_shreg <= w_load;
            r_cnt   <= '0;
            r_grant <= w_rdy1;
         end else if (r_state == S_SHIFT) begin
            r_shreg <= {r_shreg[FLEN-2:0], 1'b0};
            r_cnt   <= r_cnt + 1'b1;
         end
         if (w_last)
            r_gap <= GAP_LD;
         else if ((r_state == S_GAP) && (r_gap != 4'd0))
            r_gap <= r_gap - 4'd1;
      end
   end

   assign o_req0_ready  = w_rdy0;
   assign o_req1_ready  = w_rdy1;
   assign o_so          = (r_state == S_SHIFT) && r_shreg[FLEN-1];
   assign o_so_valid    = (r_state == S_SHIFT);
   assign o_frame_start = (r_state == S_SHIFT) && (r_cnt == '0);
   assign o_busy        = (r_state == S_SHIFT) || (r_state == S_GAP);
   assign o_grant_id    = r_grant;

endmodule
